// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: AXI4-Lite master that writes an operand pair to the adder slave and reads back the sum
module adder_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_error,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);
    typedef enum logic [2:0] {IDLE, WR_A, WR_A_RSP, WR_B, WR_B_RSP, RD_ADDR, RD_DATA, DONE} state_t;
    state_t state, state_nxt;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic aw_done, w_done, live, wr, wr_fin, b_rsp;
    assign wr = state == WR_A || state == WR_B;
    assign b_rsp = state == WR_A_RSP || state == WR_B_RSP;
    // each write channel finishes on its own handshake; both must be done to leave the write state
    assign wr_fin = (aw_done || AWREADY) && (w_done || WREADY);
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = cmd_valid && cmd_ready ? WR_A : IDLE;
            WR_A:     state_nxt = wr_fin ? WR_A_RSP : WR_A;
            WR_A_RSP: state_nxt = !BVALID ? WR_A_RSP : BRESP == 2'b00 ? WR_B : DONE;
            WR_B:     state_nxt = wr_fin ? WR_B_RSP : WR_B;
            WR_B_RSP: state_nxt = !BVALID ? WR_B_RSP : BRESP == 2'b00 ? RD_ADDR : DONE;
            RD_ADDR:  state_nxt = ARREADY ? RD_DATA : RD_ADDR;
            RD_DATA:  state_nxt = RVALID ? DONE : RD_DATA;
            DONE:     state_nxt = res_ready ? IDLE : DONE;
            default:  state_nxt = IDLE;
        endcase
    end
    always_comb begin
        cmd_ready = state == IDLE && live;
        AWVALID   = wr && !aw_done;
        WVALID    = wr && !w_done;
        AWADDR    = state == WR_A ? BASE_ADDR : state == WR_B ? BASE_ADDR + ADDR_WIDTH'(4) : '0;
        WDATA     = state == WR_A ? op_a : state == WR_B ? op_b : '0;
        WSTRB     = '1;
        BREADY    = b_rsp;
        ARVALID   = state == RD_ADDR;
        ARADDR    = state == RD_ADDR ? BASE_ADDR + ADDR_WIDTH'(8) : '0;
        RREADY    = state == RD_DATA;
        res_valid = state == DONE;
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            live      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            res_data  <= '0;
            res_error <= 1'b0;
        end else begin
            live    <= 1'b1;
            aw_done <= wr && state_nxt == state && (aw_done || AWREADY);
            w_done  <= wr && state_nxt == state && (w_done || WREADY);
            if (cmd_valid && cmd_ready) begin
                op_a <= cmd_a;
                op_b <= cmd_b;
            end
            if (state == DONE && res_ready) begin
                res_data  <= '0;
                res_error <= 1'b0;
            end else if (b_rsp && BVALID && BRESP != 2'b00) begin
                res_data  <= '0;
                res_error <= 1'b1;
            end else if (state == RD_DATA && RVALID) begin
                res_data  <= RRESP == 2'b00 ? RDATA : '0;
                res_error <= RRESP != 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed and randomized checks of adder_seq_ctrl against an AXI4-Lite adder slave model
module tb_adder_seq_ctrl;
    logic ACLK = 0, ARESETn = 0;
    logic cmd_valid = 0, cmd_ready, res_valid, res_ready = 0, res_error;
    logic [31:0] cmd_a = 0, cmd_b = 0, res_data, WDATA, RDATA = 0;
    logic [7:0] AWADDR, ARADDR;
    logic [3:0] WSTRB;
    logic [1:0] BRESP = 0, RRESP = 0;
    logic AWVALID, AWREADY = 0, WVALID, WREADY = 0, BVALID = 0, BREADY, ARVALID, ARREADY = 0, RVALID = 0, RREADY;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0] bresp_a = 0, bresp_b = 0, rresp = 0;
    bit rd_force = 0;
    logic [31:0] rd_val = 0;

    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0;
    bit have_aw = 0, have_w = 0, b_pend = 0, r_pend = 0, moved = 0;
    logic [7:0] aw_a = 0, prev_aw = 0;
    logic [31:0] w_d = 0, prev_w = 0, reg_a = 0, reg_b = 0, r_d = 0;
    logic [1:0] b_r = 0, r_r = 0;
    logic [7:0] aw_log[$], ar_log[$];
    logic [31:0] w_log[$];
    int aw_len[$], w_len[$];

    adder_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(8'h00)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // adder slave: programmable READY delays and response codes, B/R returned the cycle after handshake
    always @(posedge ACLK) begin
        if (!ARESETn) begin
            have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
        end else begin
            if (AWVALID && aw_wait > 0 && AWADDR !== prev_aw) moved = 1;
            if (WVALID && w_wait > 0 && WDATA !== prev_w) moved = 1;
            prev_aw = AWADDR;
            prev_w = WDATA;
            if (BVALID && BREADY) begin b_pend = 0; b_cnt++; end
            if (RVALID && RREADY) r_pend = 0;
            if (AWVALID && AWREADY) begin
                aw_log.push_back(AWADDR); aw_len.push_back(aw_wait + 1);
                aw_a = AWADDR; have_aw = 1; aw_wait = 0;
            end else if (AWVALID) aw_wait++;
            if (WVALID && WREADY) begin
                w_log.push_back(WDATA); w_len.push_back(w_wait + 1);
                w_d = WDATA; have_w = 1; w_wait = 0;
            end else if (WVALID) w_wait++;
            if (have_aw && have_w) begin
                if (aw_a == 8'h00) reg_a = w_d; else reg_b = w_d;
                b_r = aw_a == 8'h00 ? bresp_a : bresp_b;
                b_pend = 1; have_aw = 0; have_w = 0;
            end
            if (ARVALID && ARREADY) begin
                ar_log.push_back(ARADDR); ar_wait = 0; r_pend = 1;
                r_d = rd_force ? rd_val : reg_a + reg_b;
                r_r = rresp;
            end else if (ARVALID) ar_wait++;
        end
        #1;
        AWREADY = AWVALID && aw_wait >= aw_dly;
        WREADY  = WVALID && w_wait >= w_dly;
        ARREADY = ARVALID && ar_wait >= ar_dly;
        BVALID  = b_pend;
        BRESP   = b_pend ? b_r : 2'b00;
        RVALID  = r_pend;
        RDATA   = r_pend ? r_d : 32'h0;
        RRESP   = r_pend ? r_r : 2'b00;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        aw_log.delete(); ar_log.delete(); w_log.delete(); aw_len.delete(); w_len.delete();
        b_cnt = 0; moved = 0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        while (!cmd_ready && k < 50) begin @(negedge ACLK); k++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_a = a; cmd_b = b;
        @(negedge ACLK);
        cmd_valid = 0;
    endtask

    task automatic collect(output logic [31:0] d, output logic e, output int lat);
        lat = 1;
        while (!res_valid && lat < 100) begin @(negedge ACLK); lat++; end
        chk("res_valid_wait", res_valid, 1);
        d = res_data; e = res_error;
        res_ready = 1;
        @(negedge ACLK);
        res_ready = 0;
    endtask

    // reference: two writes then one read; the first error response ends the sequence with data 0
    task automatic txn(input logic [31:0] a, input logic [31:0] b, input string tag, output int lat);
        logic [31:0] d, exp_d;
        logic e, exp_e;
        bit ea, eb, er;
        int n_aw, n_ar;
        clear_logs();
        send(a, b);
        collect(d, e, lat);
        ea = bresp_a != 2'b00;
        eb = !ea && bresp_b != 2'b00;
        er = !ea && !eb && rresp != 2'b00;
        exp_e = ea || eb || er;
        exp_d = exp_e ? 32'h0 : a + b;
        n_aw = ea ? 1 : 2;
        n_ar = (ea || eb) ? 0 : 1;
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_err"}, e, exp_e);
        chk({tag, "_aw_count"}, aw_log.size(), n_aw);
        chk({tag, "_w_count"}, w_log.size(), n_aw);
        chk({tag, "_b_count"}, b_cnt, n_aw);
        chk({tag, "_ar_count"}, ar_log.size(), n_ar);
        chk({tag, "_aw0"}, aw_log.size() > 0 ? aw_log[0] : 8'hxx, 8'h00);
        chk({tag, "_w0"}, w_log.size() > 0 ? w_log[0] : 32'hx, a);
        if (n_aw == 2) begin
            chk({tag, "_aw1"}, aw_log.size() > 1 ? aw_log[1] : 8'hxx, 8'h04);
            chk({tag, "_w1"}, w_log.size() > 1 ? w_log[1] : 32'hx, b);
        end
        if (n_ar == 1) chk({tag, "_ar0"}, ar_log.size() > 0 ? ar_log[0] : 8'hxx, 8'h08);
        chk({tag, "_stable"}, moved, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, held;
        logic e;
        int lat, k;
        bit seen;
        repeat (3) @(negedge ACLK);
        chk("rst_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY, res_valid, cmd_ready}, 0);
        chk("rst_addr_data", {AWADDR, ARADDR, WDATA, res_data, res_error}, 0);
        chk("rst_wstrb", WSTRB, 4'hF);
        ARESETn = 1;
        chk("rst_ready_low", cmd_ready, 0);
        @(negedge ACLK);
        chk("rst_ready_after", cmd_ready, 1);

        txn(32'h5, 32'h7, "zero_wait", lat);
        chk("zero_wait_latency", lat, 7);

        aw_dly = 2;
        txn(32'h1357_9BDF, 32'h2468_ACE0, "aw_delay", lat);
        chk("aw_delay_awvalid_len", aw_len.size() > 0 ? aw_len[0] : -1, 3);
        chk("aw_delay_wvalid_len", w_len.size() > 0 ? w_len[0] : -1, 1);
        aw_dly = 0;

        bresp_a = 2'b10;
        txn(32'h10, 32'h20, "bresp_a", lat);
        bresp_a = 2'b00;

        rresp = 2'b11; rd_force = 1; rd_val = 32'hDEAD_BEEF;
        txn(32'h3, 32'h4, "rresp", lat);
        rresp = 2'b00; rd_force = 0;

        send(32'h10, 32'h20);
        k = 0;
        while (!res_valid && k < 50) begin @(negedge ACLK); k++; end
        chk("hold_first_valid", res_valid, 1);
        held = res_data;
        chk("hold_first_data", held, 32'h30);
        cmd_valid = 1; cmd_a = 32'hFFFF_FFFF; cmd_b = 32'h1;
        repeat (5) begin
            @(negedge ACLK);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 32'h30);
            chk("hold_busy", cmd_ready, 0);
        end
        res_ready = 1;
        @(negedge ACLK);
        res_ready = 0;
        chk("hold_ready_after_hs", cmd_ready, 1);
        @(negedge ACLK);
        cmd_valid = 0;
        chk("hold_accepted", cmd_ready, 0);
        collect(d, e, lat);
        chk("wrap_data", d, 32'h0);
        chk("wrap_err", e, 0);
        chk("wrap_latency", lat, 7);

        clear_logs();
        send(32'h11, 32'h22);
        k = 0;
        while (!(BREADY && aw_log.size() == 2) && k < 50) begin @(negedge ACLK); k++; end
        chk("mid_rst_in_wr_b_rsp", BREADY && aw_log.size() == 2, 1);
        ARESETn = 0;
        @(negedge ACLK);
        chk("mid_rst_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY, res_valid, cmd_ready}, 0);
        chk("mid_rst_addr_data", {AWADDR, ARADDR, WDATA, res_data, res_error}, 0);
        ARESETn = 1;
        @(negedge ACLK);
        chk("mid_rst_ready_after", cmd_ready, 1);
        seen = 0;
        repeat (10) begin @(negedge ACLK); seen |= res_valid; end
        chk("mid_rst_no_result", seen, 0);
        chk("mid_rst_no_read", ar_log.size(), 0);
        txn(32'h1234, 32'h4321, "post_rst", lat);
        chk("post_rst_latency", lat, 7);

        for (int i = 0; i < 16; i++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            bresp_a = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            bresp_b = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            rresp = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            txn($urandom, $urandom, "rand", lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

AXI4-Lite master sequencer that drives the memory-mapped adder slave. It accepts an operand pair on a valid/ready command port and writes operand A and operand B into the adder's registers. It then reads back the sum and returns it with an error flag on a valid/ready result port. It sits between a processing client and the adder slave, and is the only master on that AXI4-Lite link.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width and operand/result width
- ADDR_WIDTH, 8, AXI address width
- BASE_ADDR, 0, adder base address. Register offsets: +0x00 operand A (W), +0x04 operand B (W), +0x08 sum (R).

Ports:
- ACLK  in  1  single clock; all logic rising-edge
- ARESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  operand pair valid
- cmd_ready  out  1  sequencer idle, command accepted on valid&ready
- cmd_a / cmd_b  in  DATA_WIDTH  operands
- res_valid  out  1  result available
- res_ready  in  1  client accepts result
- res_data  out  DATA_WIDTH  sum read from adder (0 on error)
- res_error  out  1  any BRESP/RRESP != 2'b00
- AWADDR  out  ADDR_WIDTH; AWVALID out 1; AWREADY in 1
- WDATA  out  DATA_WIDTH; WSTRB out DATA_WIDTH/8 (always all-ones); WVALID out 1; WREADY in 1
- BRESP  in  2; BVALID in 1; BREADY out 1
- ARADDR  out  ADDR_WIDTH; ARVALID out 1; ARREADY in 1
- RDATA  in  DATA_WIDTH; RRESP in 2; RVALID in 1; RREADY out 1

## Operation
- FSM states: IDLE, WR_A, WR_A_RSP, WR_B, WR_B_RSP, RD_ADDR, RD_DATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_a/cmd_b into internal registers and go to WR_A.
- WR_A / WR_B:
  - AWVALID and WVALID rise together. AWADDR = BASE_ADDR+0x00 or +0x04; WDATA = latched A or B.
  - Each VALID drops independently on its own handshake; the side already done stays low.
  - Move to the matching _RSP state once both handshakes are complete, including same-cycle completion.
- WR_x_RSP: BREADY=1.
  - On BVALID with BRESP==00, advance (WR_A_RSP to WR_B, WR_B_RSP to RD_ADDR).
  - On BRESP!=00, set the error flag, clear the result data and go straight to DONE.
- RD_ADDR: ARVALID=1, ARADDR = BASE_ADDR+0x08. On ARREADY go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA, or 0 plus the error flag if RRESP!=00, then go to DONE.
- DONE: res_valid=1 with res_data/res_error stable. On res_ready go to IDLE; the error flag clears.
- Address and data outputs hold their values while the corresponding VALID is high.
- No AXI transaction is ever abandoned once started. There is no timeout.
- The adder's arithmetic is not recomputed; res_data is exactly the RDATA returned.

## Timing
- Reset (ARESETn low at a clock edge):
  - State goes to IDLE.
  - All VALID/READY outputs (AWVALID, WVALID, BREADY, ARVALID, RREADY, res_valid) = 0; cmd_ready = 0.
  - AWADDR, WDATA, ARADDR, res_data and res_error = 0; WSTRB = all-ones.
  - cmd_ready = 1 the first cycle after ARESETn is sampled high.
- Reset mid-operation: outstanding VALIDs drop the next cycle and the latched operands are discarded. No response is produced.
- All outputs are registered or decoded from the state register only. There is no combinational path from AXI inputs to AXI outputs.
- Latency with a zero-wait slave (READY always 1, B/R valid the cycle after handshake):
  - command accepted at T
  - AW/W handshake at T+1, B at T+2
  - AW/W handshake at T+3, B at T+4
  - AR at T+5, R at T+6
  - res_valid at T+7
- Back-to-back: a new command can be accepted the cycle after the res_valid&res_ready handshake.
- cmd_ready = 0 in every non-IDLE state. Commands offered while busy wait.

## Test plan
- Zero-wait slave model, A=0x0000_0005, B=0x0000_0007, slave sum 0x0000_000C -> writes to 0x00 and 0x04, read of 0x08, res_data=0x0000_000C, res_error=0, res_valid at T+7.
- AWREADY delayed 3 cycles, WREADY immediate, on the A write -> WVALID drops after 1 cycle, AWVALID holds 3 cycles with a stable address, and exactly one B is consumed.
- BRESP=2'b10 on the operand-A write -> no B write or AR issued, res_valid with res_error=1 and res_data=0.
- RRESP=2'b11 with RDATA=0xDEAD_BEEF -> res_error=1, res_data=0.
- res_ready held low 5 cycles, with cmd_valid high and A=0xFFFF_FFFF, B=1 -> res_valid and data held stable; the second command is accepted the cycle after the handshake; wrap sum 0x0000_0000 is returned.
- ARESETn pulsed low during WR_B_RSP -> next cycle all VALIDs are 0 and no res_valid follows; cmd_ready=1 after release, and a following command completes normally.
